i2c_master_byte: RTL
====================

Name: i2c_master_byte

Overview:
- Byte-level I2C master controller that drives the bus toward EEPROM-style slaves, including the 256-byte simulation EEPROM slave model.
- Accepts one command at a time over a valid/ready interface: START (or repeated START), WRITE byte, READ byte, STOP.
- Generates SCL and open-drain SDA timing from a fixed clock divider.
- Returns a one-cycle response carrying read data, the received ACK bit and an error flag.
- Sits between a register/DMA front end and the I2C pads or slave model.

Parameters:
- CLK_DIV, 16, clk_i cycles per quarter SCL period. Legal minimum is 2. SCL period = 4*CLK_DIV.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  controller idle, can accept a command
- cmd_i  in  2  command code: 00 START, 01 WRITE, 10 READ, 11 STOP
- wdata_i  in  8  byte for WRITE, sampled at accept
- mack_i  in  1  ACK level master drives after READ (0=ACK, 1=NACK), sampled at accept
- rsp_valid_o  out  1  one-cycle completion pulse
- rdata_o  out  8  byte received by READ, held until next READ completes
- ack_o  out  1  SDA level sampled in 9th bit of WRITE (0=slave ACK), held
- err_o  out  1  completed command was illegal, held until next rsp_valid_o
- bus_busy_o  out  1  bus owned (between START and STOP completion)
- scl_o  out  1  SCL level
- sda_i  in  1  SDA line (wired-AND)
- sda_o  out  1  SDA drive value
- sda_oe_o  out  1  SDA drive enable

Behaviour:
- Reset (rst_i=1 at clk_i edge): cmd_ready_o=1, rsp_valid_o=0, rdata_o=0, ack_o=1, err_o=0, bus_busy_o=0, scl_o=1, sda_o=1, sda_oe_o=0. Takes effect from any state including mid-byte. No STOP is generated.
- Releasing SDA means sda_oe_o=0, sda_o=1. Driving low means sda_oe_o=1, sda_o=0. A 1 bit is always sent by releasing, never by driving high.
- States: IDLE, START, BIT, STOP, DONE. Quarter counter 0..CLK_DIV-1, quarter index q0..q3, bit counter 8..0.
- Accept when cmd_valid_i && cmd_ready_o. cmd_ready_o goes low the next cycle. Commands presented while cmd_ready_o=0 are ignored.
- START (legal with bus idle or busy; busy gives repeated START):
  - q0: SCL=0, SDA released.
  - q1: SCL=1, SDA released.
  - q2: SCL=1, SDA low.
  - q3: SCL=0, SDA low.
  - Sets bus_busy_o at completion.
- WRITE: 9 bit slots, MSB first; slot 9 is ACK.
  - Each slot: q0 SCL=0 with SDA set to the bit; q1 and q2 SCL=1; q3 SCL=0.
  - SDA changes only in q0 cycle 0.
  - In slot 9 SDA is released, and sda_i is sampled on the last cycle of q2 into ack_o.
- READ: SDA released in slots 1-8.
  - sda_i is sampled on the last cycle of q2 and shifted in MSB first to rdata_o.
  - Slot 9 drives mack_i using the WRITE timing.
- STOP:
  - q0: SCL=0, SDA low.
  - q1: SCL=1, SDA low.
  - q2: SCL=1, SDA released.
  - q3: SCL=1, SDA released.
  - Clears bus_busy_o at completion.
- Latency from the accept edge to rsp_valid_o: START/STOP 4*CLK_DIV+1 cycles; WRITE/READ 36*CLK_DIV+1 cycles. cmd_ready_o returns high in the same cycle as rsp_valid_o.
- Illegal commands: WRITE, READ or STOP with bus_busy_o=0.
  - Accepted, but no bus activity.
  - rsp_valid_o=1 and err_o=1 in the next cycle.
  - rdata_o and ack_o are unchanged.
- Legal completions clear err_o.
- Not supported: clock stretching, arbitration loss, 10-bit addressing. scl_o is push-pull.

Test Plan:
- Assert rst_i for 2 cycles with CLK_DIV=4 -> all outputs at their reset values; scl_o=1; sda_oe_o=0; cmd_ready_o=1.
- START, then WRITE 0xA0 to the EEPROM model at 7'h50 -> ack_o=0; WRITE rsp_valid_o arrives exactly 145 cycles after accept; SDA never changes while scl_o=1 except during START/STOP.
- START, WRITE 0xA4 (no slave at 7'h52), STOP -> ack_o=1, err_o=0, bus_busy_o=0 after STOP.
- Transaction 1: START, WRITE 0xA0, WRITE 0x10, WRITE 0x5A, STOP. Transaction 2: START, WRITE 0xA0, WRITE 0x10, START, WRITE 0xA1, READ with mack_i=0, READ with mack_i=1, STOP -> rdata_o is 0x5A then 0xFF.
- WRITE 0x55 with bus idle -> rsp_valid_o and err_o=1 one cycle after accept; scl_o stays 1; sda_oe_o stays 0.
- Assert rst_i during slot 4 of a WRITE -> next cycle scl_o=1, sda_oe_o=0, bus_busy_o=0, cmd_ready_o=1; a following START completes normally.

Source files
------------

// File: rtl/i2c_master_byte.sv
// Byte-level I2C master: START / WRITE / READ / STOP commands over valid/ready,
// quarter-period SCL timing from a fixed divider, open-drain SDA.
module i2c_master_byte #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_i,
  input  logic [7:0] wdata_i,
  input  logic       mack_i,
  output logic       rsp_valid_o,
  output logic [7:0] rdata_o,
  output logic       ack_o,
  output logic       err_o,
  output logic       bus_busy_o,
  output logic       scl_o,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oe_o
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_STOP  = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_DONE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [1:0]      qtr, qtr_n;
  logic [3:0]      bit_cnt, bit_n;
  logic [8:0]      sh, sh_n;
  logic [7:0]      rx, rx_n;
  logic            ack_r, ack_r_n;
  logic            illegal, illegal_n;
  logic [1:0]      op, op_n;

  logic            ready_n, rsp_n, ack_n, err_n, busy_n, scl_n, sda_n, oe_n;
  logic [7:0]      rdata_n;
  logic            last_q, slot_end, drive_bus, drv_low;

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      cnt         <= '0;
      qtr         <= '0;
      bit_cnt     <= '0;
      sh          <= '0;
      rx          <= '0;
      ack_r       <= 1'b1;
      illegal     <= 1'b0;
      op          <= CMD_START;
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rdata_o     <= '0;
      ack_o       <= 1'b1;
      err_o       <= 1'b0;
      bus_busy_o  <= 1'b0;
      scl_o       <= 1'b1;
      sda_o       <= 1'b1;
      sda_oe_o    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      qtr         <= qtr_n;
      bit_cnt     <= bit_n;
      sh          <= sh_n;
      rx          <= rx_n;
      ack_r       <= ack_r_n;
      illegal     <= illegal_n;
      op          <= op_n;
      cmd_ready_o <= ready_n;
      rsp_valid_o <= rsp_n;
      rdata_o     <= rdata_n;
      ack_o       <= ack_n;
      err_o       <= err_n;
      bus_busy_o  <= busy_n;
      scl_o       <= scl_n;
      sda_o       <= sda_n;
      sda_oe_o    <= oe_n;
    end
  end

  // Next state; bus pins are registered from the position being entered
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    qtr_n     = qtr;
    bit_n     = bit_cnt;
    sh_n      = sh;
    rx_n      = rx;
    ack_r_n   = ack_r;
    illegal_n = illegal;
    op_n      = op;
    ready_n   = cmd_ready_o;
    rsp_n     = 1'b0;
    rdata_n   = rdata_o;
    ack_n     = ack_o;
    err_n     = err_o;
    busy_n    = bus_busy_o;
    scl_n     = scl_o;
    sda_n     = sda_o;
    oe_n      = sda_oe_o;
    drive_bus = 1'b0;
    drv_low   = 1'b0;
    last_q    = (cnt == CW'(CLK_DIV - 1));
    slot_end  = last_q && (qtr == 2'd3);

    if ((state == S_START) || (state == S_BIT) || (state == S_STOP)) begin
      cnt_n = last_q ? '0 : cnt + 1'b1;
      if (last_q) qtr_n = qtr + 2'd1;
    end

    case (state)
      S_IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          ready_n   = 1'b0;
          op_n      = cmd_i;
          cnt_n     = '0;
          qtr_n     = '0;
          bit_n     = 4'd8;
          sh_n      = (cmd_i == CMD_WRITE) ? {wdata_i, 1'b1} : {8'hFF, mack_i};
          illegal_n = (cmd_i != CMD_START) && !bus_busy_o;
          if (illegal_n) begin
            state_n = S_DONE;
          end else begin
            case (cmd_i)
              CMD_START: state_n = S_START;
              CMD_STOP:  state_n = S_STOP;
              default:   state_n = S_BIT;
            endcase
          end
        end
      end
      S_START, S_STOP: begin
        if (slot_end) state_n = S_DONE;
      end
      S_BIT: begin
        // Sample at the end of SCL high: data bits shift in, slot 9 is the ACK
        if ((qtr == 2'd2) && last_q) begin
          if (bit_cnt != 4'd0) rx_n = {rx[6:0], sda_i};
          else                 ack_r_n = sda_i;
        end
        if (slot_end) begin
          if (bit_cnt == 4'd0) state_n = S_DONE;
          else                 bit_n = bit_cnt - 4'd1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        rsp_n   = 1'b1;
        ready_n = 1'b1;
        err_n   = illegal;
        if (!illegal) begin
          case (op)
            CMD_START: busy_n  = 1'b1;
            CMD_STOP:  busy_n  = 1'b0;
            CMD_WRITE: ack_n   = ack_r;
            default:   rdata_n = rx;
          endcase
        end
      end
      default: state_n = S_IDLE;
    endcase

    case (state_n)
      S_START: begin
        drive_bus = 1'b1;
        scl_n     = (qtr_n == 2'd1) || (qtr_n == 2'd2);
        drv_low   = qtr_n[1];
      end
      S_STOP: begin
        drive_bus = 1'b1;
        scl_n     = (qtr_n != 2'd0);
        drv_low   = !qtr_n[1];
      end
      S_BIT: begin
        drive_bus = 1'b1;
        scl_n     = (qtr_n == 2'd1) || (qtr_n == 2'd2);
        drv_low   = !sh_n[bit_n];
      end
      default: ;
    endcase

    // A 1 is always sent by releasing the line
    if (drive_bus) begin
      oe_n  = drv_low;
      sda_n = !drv_low;
    end
  end

endmodule
